// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction words over a req/ack
// handshake, and holds the result in the instruction register for control.
module instr_fetch_unit #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 36,
  parameter int RESET_PC = 0,
  parameter int TGT_LSB  = 14,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic               fetch_req,
  output logic               fetch_busy,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               fetch_err
);

  // Memory handshake: a read is outstanding while imem_req is high; imem_addr
  // is held stable, and the word is taken in the first cycle imem_ack is high.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    RETRY = 3'd2,
    IDLE  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PC_W-1:0]    pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               req_n, valid_n, halted_n, err_n, busy_n;
  logic [PC_W-1:0]    target;

  assign imem_addr = pc;
  assign target    = instruction[TGT_LSB+PC_W-1:TGT_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      cnt         <= '0;
      pc          <= PC_W'(RESET_PC);
      instruction <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_busy  <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      instruction <= instr_n;
      imem_req    <= req_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
      fetch_err   <= err_n;
      fetch_busy  <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pc_n     = pc;
    instr_n  = instruction;
    req_n    = imem_req;
    valid_n  = 1'b0;
    halted_n = halted;
    err_n    = 1'b0;
    case (state)
      BOOT: begin
        state_n = REQ;
        req_n   = 1'b1;
        cnt_n   = '0;
      end
      REQ: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = RETRY;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RETRY: begin
        req_n   = 1'b1;
        cnt_n   = '0;
        state_n = REQ;
      end
      IDLE: begin
        if (fetch_req) begin
          case (pc_sel)
            2'b00: begin
              req_n   = 1'b1;
              state_n = REQ;
            end
            2'b01: begin
              pc_n    = pc + 1'b1;
              req_n   = 1'b1;
              state_n = REQ;
            end
            2'b10: begin
              pc_n    = target;
              req_n   = 1'b1;
              state_n = REQ;
            end
            default: begin
              halted_n = 1'b1;
              state_n  = HALT;
            end
          endcase
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = BOOT;
      end
    endcase
    busy_n = !((state_n == IDLE) || (state_n == HALT));
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot fetch, PC increment/wrap, jump,
// ack timeout and retry, halt, and asynchronous reset during a read.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        fetch_req;
  logic        fetch_busy;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [35:0] imem_rdata;
  logic [35:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  logic        fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  // memory model: acks once `mute` cycles of the current fetch have elapsed
  logic [35:0] mem [256];
  int          mute = 0;
  int          busy_cyc = 0;
  logic        auto_mode = 1'b1;
  logic        model_ack = 1'b0;
  logic [35:0] model_rdata = '0;
  logic        man_ack = 1'b0;
  logic [35:0] man_rdata = '0;

  assign imem_ack   = auto_mode ? model_ack : man_ack;
  assign imem_rdata = auto_mode ? model_rdata : man_rdata;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .fetch_req   (fetch_req),
    .fetch_busy  (fetch_busy),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst || !fetch_busy) begin
      busy_cyc    = 0;
      model_ack   = 1'b0;
      model_rdata = '0;
    end else begin
      model_ack   = imem_req && (busy_cyc >= mute);
      model_rdata = model_ack ? mem[imem_addr] : '0;
      busy_cyc    = busy_cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [1:0] sel, input logic [7:0] exp_pc, input logic [35:0] exp_instr);
    fetch_req = 1'b1;
    pc_sel    = sel;
    tick();
    fetch_req = 1'b0;
    check("fetch_pc", pc, exp_pc);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_req_hi", imem_req, 1);
    check("fetch_busy_hi", fetch_busy, 1);
    check("fetch_valid_early", instr_valid, 0);
    tick();
    check("fetch_valid", instr_valid, 1);
    check("fetch_instr", instruction, exp_instr);
    check("fetch_req_lo", imem_req, 0);
    check("fetch_busy_lo", fetch_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 36'h100 + 36'(i);
    mem[0]     = 36'h0_0000_0004;
    mem[6]     = 36'h0_000E_8000;  // target field = 8'h3A
    mem[8'h3A] = 36'h0_003F_C000;  // target field = 8'hFF
    mem[8'hFF] = 36'hA_BCDE_F012;
    rst       = 1'b1;
    fetch_req = 1'b0;
    pc_sel    = 2'b00;

    // reset state
    tick();
    tick();
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 0);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_err", fetch_err, 0);
    check("rst_busy", fetch_busy, 1);

    // boot fetch, zero-wait memory
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("boot_req", imem_req, 1);
    check("boot_addr", imem_addr, 0);
    check("boot_valid0", instr_valid, 0);
    tick();
    check("boot_valid", instr_valid, 1);
    check("boot_instr", instruction, 36'h4);
    tick();
    check("boot_valid_pulse", instr_valid, 0);

    // increments up to pc=5, then 6, jumps to 3A and FF, wrap to 0, refetch
    for (int i = 1; i <= 5; i++) do_fetch(2'b01, 8'(i), 36'h100 + 36'(i));
    do_fetch(2'b01, 8'h06, 36'h0_000E_8000);
    do_fetch(2'b10, 8'h3A, 36'h0_003F_C000);
    do_fetch(2'b10, 8'hFF, 36'hA_BCDE_F012);
    do_fetch(2'b01, 8'h00, 36'h4);
    do_fetch(2'b00, 8'h00, 36'h4);

    // ack withheld for 20 cycles: timeout after 15 REQ cycles, one RETRY cycle
    mute      = 20;
    fetch_req = 1'b1;
    pc_sel    = 2'b00;
    tick();
    fetch_req = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      check($sformatf("to_err_%0d", k), fetch_err, (k == 15) ? 1 : 0);
      check($sformatf("to_req_%0d", k), imem_req, (k != 15 && k != 21) ? 1 : 0);
      check($sformatf("to_valid_%0d", k), instr_valid, (k == 21) ? 1 : 0);
      check($sformatf("to_addr_%0d", k), imem_addr, 0);
    end
    check("to_instr", instruction, 36'h4);

    // ack in the last REQ cycle before timeout is accepted
    mute      = 14;
    fetch_req = 1'b1;
    pc_sel    = 2'b01;
    tick();
    fetch_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("edge_err_%0d", k), fetch_err, 0);
      check($sformatf("edge_valid_%0d", k), instr_valid, (k == 15) ? 1 : 0);
    end
    check("edge_instr", instruction, 36'h101);
    check("edge_pc", pc, 1);
    mute = 0;

    // halt: absorbing, ignores requests and acks
    fetch_req = 1'b1;
    pc_sel    = 2'b11;
    tick();
    fetch_req = 1'b0;
    check("halt_flag", halted, 1);
    check("halt_busy", fetch_busy, 0);
    check("halt_req", imem_req, 0);
    check("halt_pc", pc, 1);
    auto_mode = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 36'h5_5555_5555;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1;
      pc_sel    = 2'(i);
      tick();
      check("halt_hold_pc", pc, 1);
      check("halt_hold_instr", instruction, 36'h101);
      check("halt_hold_flag", halted, 1);
      check("halt_hold_valid", instr_valid, 0);
    end
    fetch_req = 1'b0;
    man_ack   = 1'b0;
    auto_mode = 1'b1;

    // reset exits halt and restarts fetch
    #2;
    rst = 1'b1;
    #1;
    check("hrst_pc", pc, 0);
    check("hrst_halted", halted, 0);
    check("hrst_instr", instruction, 0);
    check("hrst_busy", fetch_busy, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("reboot_req", imem_req, 1);
    tick();
    check("reboot_valid", instr_valid, 1);
    check("reboot_instr", instruction, 36'h4);

    // reset in the middle of a 3-wait read, then a stale ack after release
    mute      = 3;
    fetch_req = 1'b1;
    pc_sel    = 2'b01;
    tick();
    fetch_req = 1'b0;
    check("mid_req", imem_req, 1);
    check("mid_pc", pc, 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_busy", fetch_busy, 1);
    check("mid_rst_instr", instruction, 0);
    check("mid_rst_valid", instr_valid, 0);
    auto_mode = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 36'hD_EAD0_BEEF;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("late_ack_instr", instruction, 0);
    check("late_ack_valid", instr_valid, 0);
    check("late_ack_req", imem_req, 1);
    tick();
    check("new_req_valid", instr_valid, 1);
    check("new_req_instr", instruction, 36'hD_EAD0_BEEF);
    man_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
